// File: rtl/alu_muldiv_pkg.sv
// Shared types and helpers for the sequential RV32M multiply/divide unit.
// Operation codes follow the RISC-V funct3 encoding of the M extension.
package alu_muldiv_pkg;

    typedef enum logic [2:0] {
        OP_MUL    = 3'b000,
        OP_MULH   = 3'b001,
        OP_MULHSU = 3'b010,
        OP_MULHU  = 3'b011,
        OP_DIV    = 3'b100,
        OP_DIVU   = 3'b101,
        OP_REM    = 3'b110,
        OP_REMU   = 3'b111
    } muldiv_op_t;

    // Literals carry an S_ prefix so they never collide with the DONE port.
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_FIX  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    // rs1 is treated as two's complement for these operations.
    function automatic logic is_signed_x(input muldiv_op_t op);
        return op inside {OP_MULH, OP_MULHSU, OP_DIV, OP_REM};
    endfunction

    // rs2 is treated as two's complement for these operations.
    function automatic logic is_signed_y(input muldiv_op_t op);
        return op inside {OP_MULH, OP_DIV, OP_REM};
    endfunction

endpackage

// File: rtl/muldiv_iter_step.sv
// One combinational iteration of the magnitude datapath.
// acc_i packs {hi, lo}:
//   multiply: hi = partial product, lo = remaining multiplier bits (shift-add, LSB first)
//   divide:   hi = partial remainder, lo = dividend bits shifting into the quotient (restoring)
module muldiv_iter_step #(
    parameter int WIDTH = 32
) (
    input  logic                 is_div_i,
    input  logic [2*WIDTH-1:0]   acc_i,
    input  logic [WIDTH-1:0]     b_i,
    output logic [2*WIDTH-1:0]   acc_o
);

    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;
    logic [WIDTH:0]   add_sum;
    logic [WIDTH:0]   trial;

    // Add-shift for multiply, trial-subtract-shift for divide.
    always_comb begin
        hi      = acc_i[2*WIDTH-1:WIDTH];
        lo      = acc_i[WIDTH-1:0];
        add_sum = {1'b0, hi} + (lo[0] ? {1'b0, b_i} : '0);
        // Partial remainder is always below the divisor, so the shifted value
        // fits in WIDTH+1 bits and trial[WIDTH] is a clean borrow flag.
        trial   = {hi, lo[WIDTH-1]} - {1'b0, b_i};
        if (is_div_i) begin
            if (trial[WIDTH]) begin
                acc_o = {hi[WIDTH-2:0], lo[WIDTH-1], lo[WIDTH-2:0], 1'b0};
            end else begin
                acc_o = {trial[WIDTH-1:0], lo[WIDTH-2:0], 1'b1};
            end
        end else begin
            acc_o = {add_sum, lo[WIDTH-1:1]};
        end
    end

endmodule

// File: rtl/alu_muldiv_seq.sv
// Sequential RV32M multiply/divide unit: operands are reduced to magnitudes at
// START, WIDTH iterations run in CALC, signs are restored in FIX and the result
// is registered on the way into DONE.
// Optional build macro MULDIV_EARLY_OUT_EN: trivial operands (divide by zero,
// signed overflow, zero multiply operand) bypass CALC/FIX with latency 1.
// Handshake: START is only honoured while READY=1; DONE is a one-cycle pulse and
// RESULTADO/ZERO are held until the next DONE.
module alu_muldiv_seq
    import alu_muldiv_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CNT_W = $clog2(WIDTH)
) (
    input  logic             CLK,
    input  logic             RST_n,
    input  logic             START,
    input  logic [2:0]       OP,
    input  logic [WIDTH-1:0] X,
    input  logic [WIDTH-1:0] Y,
    output logic             READY,
    output logic             BUSY,
    output logic             DONE,
    output logic [WIDTH-1:0] RESULTADO,
    output logic             ZERO
);

    state_t               state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    muldiv_op_t           op_q, op_d;
    logic                 sx_q, sx_d;
    logic                 sy_q, sy_d;
    logic [2*WIDTH-1:0]   acc_q, acc_d;
    logic [WIDTH-1:0]     b_q, b_d;
    logic [WIDTH-1:0]     res_q, res_d;
    logic                 zero_q, zero_d;

    muldiv_op_t           op_in;
    logic                 x_neg, y_neg;
    logic [WIDTH-1:0]     x_mag, y_mag;
    logic [2*WIDTH-1:0]   acc_step;
    logic [2*WIDTH-1:0]   prod_fix;
    logic [WIDTH-1:0]     quo_fix, rem_fix, fix_res;

    assign op_in = muldiv_op_t'(OP);

    // Operand signs and magnitudes as seen at capture time.
    always_comb begin
        x_neg = is_signed_x(op_in) & X[WIDTH-1];
        y_neg = is_signed_y(op_in) & Y[WIDTH-1];
        x_mag = x_neg ? -X : X;
        y_mag = y_neg ? -Y : Y;
    end

    muldiv_iter_step #(
        .WIDTH    (WIDTH)
    ) u_step (
        .is_div_i (op_q[2]),
        .acc_i    (acc_q),
        .b_i      (b_q),
        .acc_o    (acc_step)
    );

    // Sign correction and output-word selection once the iterations are done.
    always_comb begin
        prod_fix = (sx_q ^ sy_q) ? -acc_q : acc_q;
        // A zero divisor leaves an all-ones magnitude quotient; force it so the
        // sign correction cannot turn it into +1.
        quo_fix  = (b_q == '0) ? '1
                 : ((sx_q ^ sy_q) ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0]);
        rem_fix  = sx_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];
        case (op_q)
            OP_MUL:                        fix_res = prod_fix[WIDTH-1:0];
            OP_MULH, OP_MULHSU, OP_MULHU:  fix_res = prod_fix[2*WIDTH-1:WIDTH];
            OP_DIV, OP_DIVU:               fix_res = quo_fix;
            default:                       fix_res = rem_fix;
        endcase
    end

`ifdef MULDIV_EARLY_OUT_EN
    logic             y_zero, x_zero, ovf, early_hit;
    logic [WIDTH-1:0] early_res;

    // Detect operand pairs whose result is known without iterating.
    always_comb begin
        y_zero    = (Y == '0);
        x_zero    = (X == '0);
        ovf       = (op_in inside {OP_DIV, OP_REM})
                    && (X == {1'b1, {(WIDTH-1){1'b0}}}) && (Y == '1);
        early_res = '0;
        early_hit = 1'b0;
        if (OP[2]) begin
            early_hit = y_zero | ovf;
            if (y_zero) begin
                early_res = OP[1] ? X : '1;
            end else if (ovf) begin
                early_res = OP[1] ? '0 : X;
            end
        end else begin
            early_hit = x_zero | y_zero;
        end
    end
`endif

    // Next-state and datapath register update.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        op_d    = op_q;
        sx_d    = sx_q;
        sy_d    = sy_q;
        acc_d   = acc_q;
        b_d     = b_q;
        res_d   = res_q;
        zero_d  = zero_q;
        case (state_q)
            S_IDLE: begin
                if (START) begin
                    op_d    = op_in;
                    sx_d    = x_neg;
                    sy_d    = y_neg;
                    acc_d   = {{WIDTH{1'b0}}, x_mag};
                    b_d     = y_mag;
                    cnt_d   = '0;
                    state_d = S_CALC;
`ifdef MULDIV_EARLY_OUT_EN
                    if (early_hit) begin
                        res_d   = early_res;
                        zero_d  = (early_res == '0);
                        state_d = S_DONE;
                    end
`endif
                end
            end
            S_CALC: begin
                acc_d = acc_step;
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(WIDTH-1)) begin
                    state_d = S_FIX;
                end
            end
            S_FIX: begin
                res_d   = fix_res;
                zero_d  = (fix_res == '0);
                state_d = S_DONE;
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and datapath registers; reset aborts any operation in flight.
    always_ff @(posedge CLK or negedge RST_n) begin
        if (!RST_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            op_q    <= OP_MUL;
            sx_q    <= 1'b0;
            sy_q    <= 1'b0;
            acc_q   <= '0;
            b_q     <= '0;
            res_q   <= '0;
            zero_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            op_q    <= op_d;
            sx_q    <= sx_d;
            sy_q    <= sy_d;
            acc_q   <= acc_d;
            b_q     <= b_d;
            res_q   <= res_d;
            zero_q  <= zero_d;
        end
    end

    assign READY     = (state_q == S_IDLE);
    assign BUSY      = (state_q != S_IDLE);
    assign DONE      = (state_q == S_DONE);
    assign RESULTADO = res_q;
    assign ZERO      = zero_q;

endmodule
